// File: rtl/fpu_pkg.sv
// Shared floating-point constants and the exponent classification enum
// used by the calculation unit's exponent path.
package fpu_pkg;

    localparam int EXP_BIAS       = 127;
    localparam int EXP_MAX        = 255;
    localparam int EXP_WIDTH      = 8;
    localparam int EXP_DIFF_WIDTH = 10;
    localparam int SHIFT_WIDTH    = 5;
    // One extra bit over the difference so rebias can never wrap (-130..382).
    localparam int SUM_WIDTH      = EXP_DIFF_WIDTH + 1;

    typedef enum logic [1:0] {
        EXP_NORMAL,
        EXP_DENORMAL,
        EXP_OVERFLOW
    } exponent_class_t;

endpackage

// File: rtl/calculation_unit_exponent_classifier.sv
// Combinational classification of a rebiased exponent sum into normal,
// denormal (with saturated right-shift count) or overflow.
module calculation_unit_exponent_classifier
    import fpu_pkg::*;
#(
    parameter int MAX_SHIFT = 31
) (
    input  logic signed [SUM_WIDTH-1:0]   i_sum,
    output logic        [EXP_WIDTH-1:0]   o_exponent,
    output logic        [SHIFT_WIDTH-1:0] o_shift,
    output logic                          o_overflow,
    output logic                          o_underflow
);

    localparam logic signed [SUM_WIDTH-1:0] EXP_MAX_S   = SUM_WIDTH'(EXP_MAX);
    localparam logic signed [SUM_WIDTH-1:0] MAX_SHIFT_S = SUM_WIDTH'(MAX_SHIFT);
    localparam logic signed [SUM_WIDTH-1:0] ONE_S       = SUM_WIDTH'(1);

    exponent_class_t w_class;

    // Shift is formed at full sum width and clamped before it is narrowed.
    function automatic logic [SHIFT_WIDTH-1:0] sat_shift(input logic signed [SUM_WIDTH-1:0] sum);
        logic signed [SUM_WIDTH-1:0] raw;
        raw = ONE_S - sum;
        if (raw > MAX_SHIFT_S) begin
            return MAX_SHIFT_S[SHIFT_WIDTH-1:0];
        end
        return raw[SHIFT_WIDTH-1:0];
    endfunction

    always_comb begin
        w_class = EXP_NORMAL;
        if (i_sum >= EXP_MAX_S) begin
            w_class = EXP_OVERFLOW;
        end else if (i_sum < ONE_S) begin
            w_class = EXP_DENORMAL;
        end
    end

    always_comb begin
        o_exponent  = '0;
        o_shift     = '0;
        o_overflow  = 1'b0;
        o_underflow = 1'b0;
        case (w_class)
            EXP_OVERFLOW: begin
                o_exponent = EXP_MAX_S[EXP_WIDTH-1:0];
                o_overflow = 1'b1;
            end
            EXP_DENORMAL: begin
                o_shift     = sat_shift(i_sum);
                o_underflow = 1'b1;
            end
            default: begin
                o_exponent = i_sum[EXP_WIDTH-1:0];
            end
        endcase
    end

endmodule

// File: rtl/calculation_unit_exponent_rebias_pipe.sv
// Two-stage valid/ready pipe: rebias the signed exponent difference of a
// division, then classify it into final exponent, shift and flags.
module calculation_unit_exponent_rebias_pipe
    import fpu_pkg::*;
#(
    parameter int TAG_WIDTH = 4,
    parameter int BIAS      = 127,
    parameter int MAX_SHIFT = 31
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_DIFF_WIDTH-1:0] exponent_subtractor,
    input  logic                      normalize_adjust,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_WIDTH-1:0]      result_exponent,
    output logic [SHIFT_WIDTH-1:0]    denormal_shift,
    output logic                      overflow,
    output logic                      underflow,
    output logic [TAG_WIDTH-1:0]      out_tag
);

    localparam logic signed [SUM_WIDTH-1:0] BIAS_S = SUM_WIDTH'(BIAS);

    logic                          w_advance1;
    logic                          w_advance2;
    logic signed [SUM_WIDTH-1:0]   w_diff_sext;
    logic signed [SUM_WIDTH-1:0]   w_adjust;
    logic signed [SUM_WIDTH-1:0]   w_sum;
    logic [EXP_WIDTH-1:0]          w_exponent;
    logic [SHIFT_WIDTH-1:0]        w_shift;
    logic                          w_overflow;
    logic                          w_underflow;

    logic                          r_vld_p1;
    logic signed [SUM_WIDTH-1:0]   r_sum_p1;
    logic [TAG_WIDTH-1:0]          r_tag_p1;

    logic                          r_vld_p2;
    logic [EXP_WIDTH-1:0]          r_exponent_p2;
    logic [SHIFT_WIDTH-1:0]        r_shift_p2;
    logic                          r_overflow_p2;
    logic                          r_underflow_p2;
    logic [TAG_WIDTH-1:0]          r_tag_p2;

    assign w_advance2 = !r_vld_p2 || out_ready;
    assign w_advance1 = !r_vld_p1 || w_advance2;
    assign in_ready   = w_advance1;

    assign w_diff_sext = signed'({exponent_subtractor[EXP_DIFF_WIDTH-1], exponent_subtractor});
    assign w_adjust    = signed'({{(SUM_WIDTH-1){1'b0}}, normalize_adjust});
    assign w_sum       = w_diff_sext + BIAS_S - w_adjust;

    // Stage 1: rebias
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_p1 <= 1'b0;
            r_sum_p1 <= '0;
            r_tag_p1 <= '0;
        end else if (w_advance1) begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_sum_p1 <= w_sum;
                r_tag_p1 <= in_tag;
            end
        end
    end

    calculation_unit_exponent_classifier #(
        .MAX_SHIFT (MAX_SHIFT)
    ) u_classifier (
        .i_sum       (r_sum_p1),
        .o_exponent  (w_exponent),
        .o_shift     (w_shift),
        .o_overflow  (w_overflow),
        .o_underflow (w_underflow)
    );

    // Stage 2: classified result, held while downstream stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_p2       <= 1'b0;
            r_exponent_p2  <= '0;
            r_shift_p2     <= '0;
            r_overflow_p2  <= 1'b0;
            r_underflow_p2 <= 1'b0;
            r_tag_p2       <= '0;
        end else if (w_advance2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_exponent_p2  <= w_exponent;
                r_shift_p2     <= w_shift;
                r_overflow_p2  <= w_overflow;
                r_underflow_p2 <= w_underflow;
                r_tag_p2       <= r_tag_p1;
            end
        end
    end

    assign out_valid       = r_vld_p2;
    assign result_exponent = r_exponent_p2;
    assign denormal_shift  = r_shift_p2;
    assign overflow        = r_overflow_p2;
    assign underflow       = r_underflow_p2;
    assign out_tag         = r_tag_p2;

endmodule

// File: tb/tb_calculation_unit_exponent_rebias_pipe.sv
// Bench for the exponent rebias pipe: directed vector table, backpressure
// and reset sequences, and a random stream against a queue-based model.
module tb_calculation_unit_exponent_rebias_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] exponent_subtractor;
    logic       normalize_adjust;
    logic [3:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result_exponent;
    logic [4:0] denormal_shift;
    logic       overflow;
    logic       underflow;
    logic [3:0] out_tag;

    calculation_unit_exponent_rebias_pipe #(
        .TAG_WIDTH (4),
        .BIAS      (127),
        .MAX_SHIFT (31)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .exponent_subtractor (exponent_subtractor),
        .normalize_adjust    (normalize_adjust),
        .in_tag              (in_tag),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .result_exponent     (result_exponent),
        .denormal_shift      (denormal_shift),
        .overflow            (overflow),
        .underflow           (underflow),
        .out_tag             (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] diff;
        logic       adj;
        logic [3:0] tag;
        int         e_exp;
        int         e_shift;
        int         e_ov;
        int         e_un;
    } vec_t;

    typedef struct {
        int e;
        int sh;
        int ov;
        int un;
        int tag;
    } res_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t exp_q[$];
    bit   stall_prev = 1'b0;
    res_t held;
    int   n_out = 0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic from the classification rules.
    function automatic res_t ref_model(input logic [9:0] diff, input logic adj, input logic [3:0] tag);
        res_t r;
        int d, s;
        d = diff[9] ? int'(diff) - 1024 : int'(diff);
        s = d + 127 - int'(adj);
        r.tag = int'(tag);
        r.e = 0; r.sh = 0; r.ov = 0; r.un = 0;
        if (s >= 255) begin
            r.e = 255; r.ov = 1;
        end else if (s >= 1) begin
            r.e = s;
        end else begin
            r.un = 1;
            r.sh = (1 - s > 31) ? 31 : 1 - s;
        end
        return r;
    endfunction

    task automatic check_out(input string name, input res_t r);
        check({name, "_exp"},   int'(result_exponent), r.e);
        check({name, "_shift"}, int'(denormal_shift),  r.sh);
        check({name, "_ov"},    int'(overflow),        r.ov);
        check({name, "_un"},    int'(underflow),       r.un);
        check({name, "_tag"},   int'(out_tag),         r.tag);
    endtask

    // One streaming cycle: drive at negedge, observe, update the model queue.
    task automatic step(input bit iv, input logic [9:0] d, input bit a,
                        input logic [3:0] t, input bit ordy, output bit acc);
        res_t r;
        @(negedge clk);
        in_valid = iv; exponent_subtractor = d; normalize_adjust = a;
        in_tag = t; out_ready = ordy;
        #1;
        if (stall_prev) begin
            check("hold_valid", int'(out_valid), 1);
            check_out("hold", held);
        end
        check("in_ready", int'(in_ready), (exp_q.size() == 2 && !ordy) ? 0 : 1);
        acc = iv && in_ready;
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                r = exp_q.pop_front();
                check_out("stream", r);
                n_out++;
            end
        end
        if (acc) exp_q.push_back(ref_model(d, a, t));
        stall_prev = out_valid && !ordy;
        held.e = int'(result_exponent); held.sh = int'(denormal_shift);
        held.ov = int'(overflow); held.un = int'(underflow); held.tag = int'(out_tag);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        int   n;
        res_t r;
        @(negedge clk);
        in_valid = 1'b1; exponent_subtractor = v.diff; normalize_adjust = v.adj;
        in_tag = v.tag; out_ready = 1'b1;
        #1;
        check($sformatf("vec%0d_in_ready", idx), int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 6) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("vec%0d_latency", idx), n, 2);
        r.e = v.e_exp; r.sh = v.e_shift; r.ov = v.e_ov; r.un = v.e_un; r.tag = int'(v.tag);
        check_out($sformatf("vec%0d", idx), r);
    endtask

    task automatic drain();
        bit acc;
        int guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            step(1'b0, 10'd0, 1'b0, 4'd0, 1'b1, acc);
            guard++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    vec_t vecs[13];
    bit   acc;
    int   idx, cyc;
    bit [3:0] rdy_pat;

    initial begin
        vecs[0]  = '{10'h003, 1'b0, 4'd5, 130,  0, 0, 0};
        vecs[1]  = '{10'h0C8, 1'b0, 4'd1, 255,  0, 1, 0};
        vecs[2]  = '{10'h080, 1'b1, 4'd2, 254,  0, 0, 0};
        vecs[3]  = '{10'h080, 1'b0, 4'd3, 255,  0, 1, 0};
        vecs[4]  = '{10'h37E, 1'b0, 4'd4,   0,  4, 0, 1};
        vecs[5]  = '{10'h381, 1'b0, 4'd6,   0,  1, 0, 1};
        vecs[6]  = '{10'h300, 1'b1, 4'd7,   0, 31, 0, 1};
        vecs[7]  = '{10'h3A0, 1'b0, 4'd8,  31,  0, 0, 0};
        vecs[8]  = '{10'h382, 1'b1, 4'd9,   0,  1, 0, 1};
        vecs[9]  = '{10'h382, 1'b0, 4'd10,  1,  0, 0, 0};
        vecs[10] = '{10'h363, 1'b0, 4'd11,  0, 31, 0, 1};
        vecs[11] = '{10'h364, 1'b0, 4'd12,  0, 30, 0, 1};
        vecs[12] = '{10'h0FF, 1'b1, 4'd13, 255, 0, 1, 0};

        reset_n = 1'b0; in_valid = 1'b0; exponent_subtractor = '0;
        normalize_adjust = 1'b0; in_tag = '0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready",  int'(in_ready), 1);
        check_out("rst", '{0, 0, 0, 0, 0});
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) apply_vec(vecs[i], i);

        // Backpressure: tags 0..7 back-to-back, out_ready pattern 1,0,0,1.
        rdy_pat = 4'b1001;
        idx = 0; cyc = 0; n_out = 0;
        while ((idx < 8 || exp_q.size() != 0) && cyc < 100) begin
            step(idx < 8, 10'(idx * 7), 1'b0, 4'(idx), rdy_pat[cyc % 4], acc);
            if (acc) idx++;
            cyc++;
        end
        check("bp_all_emitted", n_out, 8);
        check("bp_queue_empty", exp_q.size(), 0);

        // Random stream with random backpressure.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 10'($urandom), 1'($urandom),
                 4'($urandom), 1'($urandom_range(0, 2) != 0), acc);
        end
        drain();

        // Reset mid-stream with both stages full.
        step(1'b1, 10'h010, 1'b0, 4'd1, 1'b0, acc);
        step(1'b1, 10'h020, 1'b0, 4'd2, 1'b0, acc);
        step(1'b1, 10'h030, 1'b0, 4'd3, 1'b0, acc);
        check("full_in_ready", int'(in_ready), 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready",  int'(in_ready), 1);
        check_out("midrst", '{0, 0, 0, 0, 0});
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 10'd0, 1'b0, 4'd0, 1'b1, acc);
        apply_vec(vecs[0], 99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
